dmem_arbiter: RTL
=================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter ADDR_BUS_WIDTH, default 32, SHALL set the width of all address ports.
REQ-002 Parameter DATA_BUS_WIDTH, default 32, SHALL set the width of all data ports.
REQ-003 Parameter MEM_BYTES, default 64, SHALL be the byte depth of the attached data memory.
REQ-004 clk  in  1  SHALL be the single clock; all state updates on posedge.
REQ-005 rst_n  in  1  SHALL be the asynchronous, active-low reset.
REQ-006 a_req / b_req  in  1 each  SHALL be the request strobes: a = pipeline MEM stage, b = debug/DMA.
REQ-007 a_we / b_we  in  1 each  SHALL select write (1) or read (0).
REQ-008 a_addr / b_addr  in  ADDR_BUS_WIDTH each  SHALL be the byte addresses.
REQ-009 a_wdata / b_wdata  in  DATA_BUS_WIDTH each  SHALL be the write data.
REQ-010 a_gnt / b_gnt  out  1 each  SHALL mark request acceptance in the current cycle.
REQ-011 a_rvalid / b_rvalid  out  1 each  SHALL be one-cycle response pulses.
REQ-012 rdata  out  DATA_BUS_WIDTH  SHALL be the response data shared by both ports.
REQ-013 err  out  1  SHALL qualify the response as rejected; valid only with a_rvalid or b_rvalid.
REQ-014 mem_addr  out  ADDR_BUS_WIDTH, mem_write_data  out  DATA_BUS_WIDTH, mem_write_en  out  1  SHALL drive the memory.
REQ-015 mem_read_data  in  DATA_BUS_WIDTH  SHALL be the memory's combinational big-endian word read.

Function
REQ-016 A requester SHALL hold req, we, addr and wdata stable from assertion until the cycle its gnt is high.
REQ-017 gnt SHALL be combinational from req and the arbitration pointer; at most one of a_gnt and b_gnt is high per cycle; a lone request is granted in the same cycle.
REQ-018 Stage ARB (cycle N): the granted request is latched into the issue register (valid, port, we, addr, wdata, err_flag).
REQ-019 Stage ISSUE (cycle N+1): issue-register contents drive mem_addr and mem_write_data; mem_write_en = valid & we & ~err_flag; mem_read_data is captured into rdata.
REQ-020 Stage RESP (cycle N+2): the owning port's rvalid pulses for one cycle, for reads and writes; write responses have rdata = 0.
REQ-021 Throughput SHALL be one grant per cycle; back-to-back grants pipeline with no bubble.
REQ-022 err_flag SHALL be set when addr[1:0] != 0 or addr > MEM_BYTES-4; such a request is granted, never writes memory, and responds with err=1, rdata=0.
REQ-023 When the issue register is idle, mem_write_en SHALL be 0 and mem_addr SHALL hold its last value.
REQ-024 A withdrawn request (req dropped before gnt) SHALL be ignored; no response is generated.
REQ-025 Contention (a_req & b_req) SHALL be resolved per REQ-030/031.

Reset
REQ-026 Asserting rst_n low SHALL immediately clear gnt qualifiers, the issue and response valids, rvalid, err, mem_write_en, rdata and mem_addr to 0.
REQ-027 Reset SHALL set the arbitration pointer to "B last granted".
REQ-028 A transaction in flight at reset SHALL be dropped without a response, and no write SHALL occur after reset assertion.
REQ-029 The first edge after rst_n deassertion SHALL arbitrate normally.

Configuration
REQ-030 With DMEM_ARB_ROUND_ROBIN_EN defined: on contention, the port not granted most recently wins; the pointer updates on every grant.
REQ-031 Without DMEM_ARB_ROUND_ROBIN_EN: port A always wins contention and B waits; the pointer is unused.

Verification
REQ-032 After reset, a_req read at addr 0 -> a_gnt same cycle; a_rvalid at N+2 with rdata=0x0000000A, err=0.
REQ-033 b_req write 0xDEADBEEF to addr 8, then b read of addr 8 -> mem_write_en for one cycle at N+1; the read returns 0xDEADBEEF.
REQ-034 a_req and b_req held for 4 cycles (round-robin build) -> grants A,B,A,B; fixed build -> A,A,A,A with b_gnt=0.
REQ-035 a write to addr 6, then a write to addr 62 -> no mem_write_en; both responses err=1, rdata=0.
REQ-036 rst_n pulsed low in the ISSUE cycle of a write -> no mem_write_en, no rvalid; the next request completes normally.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter with a three-stage ARB/ISSUE/RESP pipeline.
// Port a is the pipeline MEM stage, port b is debug/DMA.
// Optional feature: define DMEM_ARB_ROUND_ROBIN_EN for round-robin contention
// resolution; otherwise port a has fixed priority.
module dmem_arbiter #(
  parameter int unsigned ADDR_BUS_WIDTH = 32,
  parameter int unsigned DATA_BUS_WIDTH = 32,
  parameter int unsigned MEM_BYTES      = 64
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      a_req,
  input  logic                      a_we,
  input  logic [ADDR_BUS_WIDTH-1:0] a_addr,
  input  logic [DATA_BUS_WIDTH-1:0] a_wdata,
  input  logic                      b_req,
  input  logic                      b_we,
  input  logic [ADDR_BUS_WIDTH-1:0] b_addr,
  input  logic [DATA_BUS_WIDTH-1:0] b_wdata,
  output logic                      a_gnt,
  output logic                      b_gnt,
  output logic                      a_rvalid,
  output logic                      b_rvalid,
  output logic [DATA_BUS_WIDTH-1:0] rdata,
  output logic                      err,
  output logic [ADDR_BUS_WIDTH-1:0] mem_addr,
  output logic [DATA_BUS_WIDTH-1:0] mem_write_data,
  output logic                      mem_write_en,
  input  logic [DATA_BUS_WIDTH-1:0] mem_read_data
);

  // Highest legal word-aligned byte address.
  localparam logic [ADDR_BUS_WIDTH-1:0] MaxAddr = ADDR_BUS_WIDTH'(MEM_BYTES - 4);

`ifdef DMEM_ARB_ROUND_ROBIN_EN
  logic last_b_q, last_b_d;

  // Round-robin grant: on contention the port not granted most recently wins.
  always_comb begin
    a_gnt    = rst_n & a_req & (~b_req | last_b_q);
    b_gnt    = rst_n & b_req & (~a_req | ~last_b_q);
    last_b_d = last_b_q;
    if (a_gnt) begin
      last_b_d = 1'b0;
    end else if (b_gnt) begin
      last_b_d = 1'b1;
    end
  end

  // Arbitration pointer; reset means "b last granted" so a wins first contention.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_b_q <= 1'b1;
    end else begin
      last_b_q <= last_b_d;
    end
  end
`else
  // Fixed priority grant: a always wins, b waits.
  always_comb begin
    a_gnt = rst_n & a_req;
    b_gnt = rst_n & b_req & ~a_req;
  end
`endif

  logic                      any_gnt;
  logic                      sel_we;
  logic [ADDR_BUS_WIDTH-1:0] sel_addr;
  logic [DATA_BUS_WIDTH-1:0] sel_wdata;
  logic                      sel_err;

  // Select the granted request and classify misaligned/out-of-range addresses.
  always_comb begin
    any_gnt   = a_gnt | b_gnt;
    sel_we    = a_gnt ? a_we    : b_we;
    sel_addr  = a_gnt ? a_addr  : b_addr;
    sel_wdata = a_gnt ? a_wdata : b_wdata;
    sel_err   = (sel_addr[1:0] != 2'b00) || (sel_addr > MaxAddr);
  end

  logic                      iss_valid_q;
  logic                      iss_port_q;   // 0 = a, 1 = b
  logic                      iss_we_q;
  logic [ADDR_BUS_WIDTH-1:0] iss_addr_q;
  logic [DATA_BUS_WIDTH-1:0] iss_wdata_q;
  logic                      iss_err_q;

  // ARB stage: latch the granted request; payload holds while idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      iss_valid_q <= 1'b0;
      iss_port_q  <= 1'b0;
      iss_we_q    <= 1'b0;
      iss_addr_q  <= '0;
      iss_wdata_q <= '0;
      iss_err_q   <= 1'b0;
    end else begin
      iss_valid_q <= any_gnt;
      if (any_gnt) begin
        iss_port_q  <= b_gnt;
        iss_we_q    <= sel_we;
        iss_addr_q  <= sel_addr;
        iss_wdata_q <= sel_wdata;
        iss_err_q   <= sel_err;
      end
    end
  end

  logic                      rsp_valid_q;
  logic                      rsp_port_q;
  logic                      rsp_err_q;
  logic [DATA_BUS_WIDTH-1:0] rdata_q;

  // ISSUE stage: capture read data (zero for writes and rejected requests).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_q <= 1'b0;
      rsp_port_q  <= 1'b0;
      rsp_err_q   <= 1'b0;
      rdata_q     <= '0;
    end else begin
      rsp_valid_q <= iss_valid_q;
      if (iss_valid_q) begin
        rsp_port_q <= iss_port_q;
        rsp_err_q  <= iss_err_q;
        rdata_q    <= (!iss_we_q && !iss_err_q) ? mem_read_data : '0;
      end
    end
  end

  // Memory drive and RESP-stage outputs.
  always_comb begin
    mem_addr       = iss_addr_q;
    mem_write_data = iss_wdata_q;
    mem_write_en   = iss_valid_q & iss_we_q & ~iss_err_q;
    a_rvalid       = rsp_valid_q & ~rsp_port_q;
    b_rvalid       = rsp_valid_q & rsp_port_q;
    err            = rsp_valid_q & rsp_err_q;
    rdata          = rdata_q;
  end

endmodule
